// File: rtl/debouncer_multi.sv
`default_nettype none
// ============================================================================
// Module      : debouncer_multi
// Description : N-channel key debouncer with press/release strobes and
//               long-press / auto-repeat detection.
// Revision    : 1.0 - initial release
// ============================================================================
module debouncer_multi #(
    parameter int CHANNELS       = 4,
    parameter int CLK_FREQ_MHZ   = 150,
    parameter int GLITCH_TIME_NS = 100,
    parameter bit KEY_ACTIVE_LOW = 1'b1,
    parameter int LONG_PRESS_US  = 1000,
    parameter bit AUTO_REPEAT    = 1'b0,
    parameter int REPEAT_US      = 200
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic [CHANNELS-1:0] key_i,
    output logic [CHANNELS-1:0] key_state_o,
    output logic [CHANNELS-1:0] key_pressed_stb_o,
    output logic [CHANNELS-1:0] key_released_stb_o,
    output logic [CHANNELS-1:0] key_long_stb_o
);

    localparam int C_G_RAW = (CLK_FREQ_MHZ * GLITCH_TIME_NS) / 1000;
    localparam int C_G     = (C_G_RAW < 1) ? 1 : C_G_RAW;
    localparam int C_L     = CLK_FREQ_MHZ * LONG_PRESS_US;
    localparam int C_R     = CLK_FREQ_MHZ * REPEAT_US;
    localparam int C_HMAX  = (C_L > C_R) ? C_L : C_R;
    localparam int C_GW    = $clog2(C_G + 1);
    localparam int C_HW    = $clog2(C_HMAX + 1);

    localparam logic [C_GW-1:0] C_G_LAST = C_GW'(C_G - 1);
    localparam logic [C_HW-1:0] C_L_LAST = C_HW'(C_L - 1);
    // Parking value once the single long strobe has fired (non-repeat mode).
    localparam logic [C_HW-1:0] C_L_SAT  = C_HW'(C_L);
    localparam logic [C_HW-1:0] C_RELOAD = (C_R >= C_L) ? '0 : C_HW'(C_L - C_R);
    localparam logic            C_IDLE   = KEY_ACTIVE_LOW;

    genvar gi;
    generate
        for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
            logic            r_sync1;
            logic            r_sync2;
            logic            r_state;
            logic            r_press_stb;
            logic            r_rel_stb;
            logic            r_long_stb;
            logic [C_GW-1:0] r_gcnt;
            logic [C_HW-1:0] r_hold;
            logic            w_s;
            logic            w_flip;

            assign w_s    = r_sync2 ^ KEY_ACTIVE_LOW;
            assign w_flip = (w_s != r_state) && (r_gcnt == C_G_LAST);

            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    r_sync1     <= C_IDLE;
                    r_sync2     <= C_IDLE;
                    r_state     <= 1'b0;
                    r_press_stb <= 1'b0;
                    r_rel_stb   <= 1'b0;
                    r_long_stb  <= 1'b0;
                    r_gcnt      <= '0;
                    r_hold      <= '0;
                end else begin
                    r_sync1     <= key_i[gi];
                    r_sync2     <= r_sync1;
                    r_press_stb <= w_flip & w_s;
                    r_rel_stb   <= w_flip & ~w_s;
                    r_long_stb  <= 1'b0;

                    if (w_s == r_state) begin
                        r_gcnt <= '0;
                    end else if (w_flip) begin
                        r_state <= w_s;
                        r_gcnt  <= '0;
                    end else begin
                        r_gcnt <= r_gcnt + C_GW'(1);
                    end

                    // A flip in either direction restarts the hold measurement.
                    if (w_flip || !r_state) begin
                        r_hold <= '0;
                    end else if (r_hold == C_L_LAST) begin
                        r_long_stb <= 1'b1;
                        r_hold     <= AUTO_REPEAT ? C_RELOAD : C_L_SAT;
                    end else if (r_hold != C_L_SAT) begin
                        r_hold <= r_hold + C_HW'(1);
                    end
                end
            end

            assign key_state_o[gi]        = r_state;
            assign key_pressed_stb_o[gi]  = r_press_stb;
            assign key_released_stb_o[gi] = r_rel_stb;
            assign key_long_stb_o[gi]     = r_long_stb;
        end
    endgenerate

endmodule
`default_nettype wire

// File: doc/debouncer_multi.md
Name: debouncer_multi

Overview:
- N-channel key debouncer with both edge strobes and long-press/auto-repeat detection. Parametrised in channel count, input polarity, glitch window and hold timings.
- Each channel has its own 2-flop synchroniser, glitch counter and hold counter. Channels are fully independent.
- Sits between raw board buttons/switches and control logic such as menu FSMs and mode selectors.

Parameters:
- CHANNELS, 4: number of independent key channels.
- CLK_FREQ_MHZ, 150: clock_i frequency in MHz.
- GLITCH_TIME_NS, 100: minimum stable time before a level change is accepted. G = max(1, CLK_FREQ_MHZ*GLITCH_TIME_NS/1000) cycles, integer division.
- KEY_ACTIVE_LOW, 1: 1 = pressed key drives 0 on key_i; 0 = pressed drives 1.
- LONG_PRESS_US, 1000: hold time to the first long strobe. L = CLK_FREQ_MHZ*LONG_PRESS_US cycles; L >= 1 required.
- AUTO_REPEAT, 0: 1 = repeat long strobe while held.
- REPEAT_US, 200: repeat period. R = CLK_FREQ_MHZ*REPEAT_US cycles; R >= 1 required when AUTO_REPEAT = 1.

Ports:
- clk_i  input  1  system clock.
- rst_ni  input  1  asynchronous active-low reset.
- key_i  input  CHANNELS  raw asynchronous key levels, one bit per channel.
- key_state_o  output  CHANNELS  debounced level, 1 = pressed.
- key_pressed_stb_o  output  CHANNELS  one-cycle strobe on accepted press.
- key_released_stb_o  output  CHANNELS  one-cycle strobe on accepted release.
- key_long_stb_o  output  CHANNELS  one-cycle strobe on long press / repeat.

Behaviour:
- Reset (rst_ni = 0, asynchronous):
  - Synchroniser flops load the inactive level (KEY_ACTIVE_LOW ? 1 : 0).
  - All counters load 0.
  - All outputs load 0.
  - No strobes on reset assertion or deassertion.
- Synchroniser: key_i passes through 2 flops per bit. s = sync2 XOR KEY_ACTIVE_LOW, so s = 1 means pressed.
- Glitch counter per channel, width clog2(G+1), evaluated every edge:
  - s == key_state: cnt <= 0.
  - s != key_state and cnt < G-1: cnt <= cnt+1.
  - s != key_state and cnt == G-1: key_state <= s, cnt <= 0. This is a "flip".
  - Any single-cycle return of s to key_state restarts the count from 0.
- Latency: new key_i level first sampled at edge E0 appears in s after E1. The flip occurs at edge E(G+1).
  - key_state_o changes at E(G+1).
  - The matching strobe is high for exactly the one cycle between E(G+1) and E(G+2).
- Strobes are registered. At the flip edge:
  - key_pressed_stb_o <= flip & s.
  - key_released_stb_o <= flip & ~s.
  - Otherwise strobes <= 0. Press and release strobes are never high together on one channel.
- Hold counter per channel, width clog2(max(L,R)+1):
  - Cleared to 0 on the press flip edge and whenever key_state = 0.
  - Increments every edge while key_state = 1.
  - When hold == L-1: key_long_stb_o <= 1.
  - If AUTO_REPEAT = 0: the counter then saturates, so there is exactly one long strobe per press.
  - If AUTO_REPEAT = 1: the counter reloads to L-R after the first strobe, giving further long strobes every R cycles while held.
- Long-strobe timing: the first long strobe is high during the cycle after edge Ep+L, where Ep is the press flip edge.
- Release before hold == L-1 gives no long strobe. A release flip clears the hold counter on the same edge.
- key_state_o is registered directly from the key_state flops.
- Channels are independent. Simultaneous events on several channels each produce their own strobes on the same cycle.
- Reset mid-operation: everything returns to reset state immediately. A key held through reset deassertion yields a press strobe G+1 edges after the first post-reset edge at which sync1 samples the pressed level.
- Bounce longer than the glitch window is accepted as a real edge. Use a GLITCH_TIME_NS larger than the key's bounce time.

Test Plan:
Bench parameters: CLK_FREQ_MHZ=10, GLITCH_TIME_NS=500 (G=5), LONG_PRESS_US=2 (L=20), REPEAT_US=1 (R=10), CHANNELS=4, KEY_ACTIVE_LOW=1.
1. Clean press then release:
   - Drive ch0 low at E0 and hold.
   - key_state_o[0]=1 at E6; key_pressed_stb_o[0] high for one cycle after E6.
   - Release later: key_released_stb_o[0] after the same latency. No long strobe if held < 20 cycles.
2. Glitch rejection: on ch1, pulses low of 1, 3 and 4 cycles, each separated by 1 high cycle -> no strobe, key_state_o[1] stays 0. A subsequent 5-cycle low is accepted.
3. Long press with AUTO_REPEAT=0: hold ch2 for 100 cycles -> exactly one key_long_stb_o[2], 20 cycles after the press strobe.
4. Long press with AUTO_REPEAT=1: hold ch2 for 60 cycles past the press flip -> long strobes at +20, +30, +40, +50, +60. None after release.
5. Simultaneous channels: press ch0 and ch3 on the same edge -> both press strobes on the same cycle. Release ch0 while ch3 is held -> ch3 state and hold count unaffected.
6. Reset mid-operation:
   - Assert rst_ni=0 during a count and during a held key -> all outputs 0 immediately.
   - After deassertion with ch0 still held low: press strobe 6 edges after sync1 samples 0. No release strobe.
